alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4-bit multi-op ALU FSM between two requesters.
- Accepts one operation at a time from requester 0 or 1 and drives the ALU's go/opcode/operand inputs.
- Waits for the ALU's done indication, then returns the 5-bit result and carry to the requester that issued the operation.
- Sits between the requester logic (switch/UI controller, test sequencer) and the ALU.

Parameters:
- TIMEOUT_CYCLES, 15: max cycles in WAIT before abort (used only with ALU_TIMEOUT_EN); legal range 2..255.
- CNT_W, 8: width of timeout counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  2  bit i = requester i has an op pending; held until accepted
- req_opcode  input  6  {op1[2:0], op0[2:0]}; 000 add, 001 sub, 010 notA, 011 notB, 100 and, 101 or, 110 xor, 111 xnor
- req_a  input  8  {a1, a0}, 4 bits each
- req_b  input  8  {b1, b0}, 4 bits each
- req_ready  output  2  one-cycle accept pulse, bit i
- rsp_valid  output  2  one-cycle response pulse, bit i
- rsp_result  output  5  result, valid with rsp_valid
- rsp_cout  output  1  carry, valid with rsp_valid
- rsp_error  output  1  timeout abort flag, valid with rsp_valid
- busy  output  1  high in any state except IDLE
- alu_go  output  1  one-cycle start pulse to ALU
- alu_opcode  output  3  latched opcode
- alu_a  output  4  latched operand a
- alu_b  output  4  latched operand b
- alu_ready  input  1  ALU idle and ready for go
- alu_done  input  1  ALU done pulse, at least 1 cycle
- alu_result  input  5  ALU result
- alu_cout  input  1  ALU carry

Behaviour:
- Reset (reset=1 at posedge) applies regardless of state, including mid-operation:
  - state=IDLE, last_grant=1 (requester 0 wins first), timer=0.
  - All outputs 0: req_ready, rsp_valid, rsp_result, rsp_cout, rsp_error, alu_go, alu_opcode, alu_a, alu_b.
  - An in-flight ALU op is abandoned; no response is issued for it.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - No req_valid bit set: stay in IDLE.
  - One bit set: grant that requester.
  - Both bits set: grant ~last_grant.
  - On grant: latch opcode/a/b into alu_* registers, pulse req_ready[g] for 1 cycle, set last_grant=g, go to ISSUE.
  - Accept-to-ISSUE latency: 1 cycle.
- ISSUE:
  - If alu_ready=1: pulse alu_go for 1 cycle, clear timer, go to WAIT.
  - Otherwise hold in ISSUE with alu_go=0.
- WAIT:
  - alu_opcode/alu_a/alu_b are held stable from ISSUE through WAIT.
  - alu_go is not sampled as done in the same cycle it is asserted; alu_done is ignored in the ISSUE cycle.
  - On the first cycle with alu_done=1: capture alu_result and alu_cout, set rsp_error=0, go to RESP.
- RESP:
  - Pulse rsp_valid[g] for exactly 1 cycle; rsp_result/rsp_cout/rsp_error are held until the next response.
  - Return to IDLE.
- New requests in RESP are not accepted until IDLE, so there is at most 1 op in flight.
- Minimum request-to-response time: 4 cycles plus ALU latency.
- Requests arriving while busy are held by the requester (req_valid stays high); the arbiter never drops them.
- req_valid deasserted before acceptance: the request is withdrawn, with no side effects.
- Fairness: under continuous requests from both requesters, grants alternate 0,1,0,1.
- Width rules:
  - Result is passed through unmodified at 5 bits.
  - Subtract borrow/wrap follows ALU semantics.
  - The arbiter performs no arithmetic except the timer.

Optional Feature:
- Macro: ALU_TIMEOUT_EN
- Defined:
  - Timer increments each WAIT cycle.
  - When the timer reaches TIMEOUT_CYCLES with no alu_done: go to RESP with rsp_result=0, rsp_cout=0, rsp_error=1.
  - alu_done on the same cycle as expiry wins: normal response, rsp_error=0.
- Undefined:
  - No timer logic; WAIT holds until alu_done.
  - rsp_error is tied to 0.

Decomposition:
- Package alu_pkg:
  - Opcode localparams OP_ADD..OP_XNOR (3-bit).
  - Arbiter state encoding ST_IDLE/ST_ISSUE/ST_WAIT/ST_RESP (2-bit).
  - Shared with the ALU and benches.
- Sub-module rr_arb2: combinational 2-way round-robin picker (inputs valid[1:0], last; outputs gnt_id, gnt_any). The FSM and latches remain in alu_arbiter.

Test Plan:
- Reset, then req_valid=01, op0=000, a0=9, b0=8 -> req_ready=01 next cycle, alu_go one pulse, rsp_valid=01 with rsp_result=5'b10001, rsp_cout per ALU, rsp_error=0.
- req_valid=11 held high for four ops (op0=100 a0=F b0=3; op1=110 a1=A b1=5) -> grant order 0,1,0,1; results 00011 and 01111 routed to correct rsp_valid bits.
- alu_ready held 0 for 5 cycles in ISSUE -> alu_go stays 0, then pulses once when alu_ready rises; operands stable throughout.
- Reset asserted 2 cycles into WAIT -> next cycle all outputs 0, busy=0, no rsp_valid; a subsequent request is granted to requester 0.
- ALU_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, alu_done never asserted -> rsp_valid pulse with rsp_error=1, rsp_result=0; macro undefined: busy stays 1 indefinitely.
- req_valid[1] raised during WAIT of a requester-0 op -> not accepted until IDLE, then req_ready=10 one cycle after RESP.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcodes and arbiter state encoding for the ALU, its arbiter and benches.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NOTA = 3'b010;
  localparam logic [2:0] OP_NOTB = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker: a lone requester wins, a tie goes to
// the requester that did not win last.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       gnt_id,
  output logic       gnt_any
);

  assign gnt_any = |valid;
  assign gnt_id  = (valid == 2'b11) ? ~last : valid[1];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one 4-bit ALU between two requesters, one op in flight.
// Optional WAIT timeout abort is enabled by defining ALU_TIMEOUT_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [5:0] req_opcode,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic [1:0] req_ready,
  output logic [1:0] rsp_valid,
  output logic [4:0] rsp_result,
  output logic       rsp_cout,
  output logic       rsp_error,
  output logic       busy,
  output logic       alu_go,
  output logic [2:0] alu_opcode,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic       alu_ready,
  input  logic       alu_done,
  input  logic [4:0] alu_result,
  input  logic       alu_cout
);

  arb_state_t state, state_next;
  logic       last_grant;
  logic       gnt_id;
  logic       gnt_any;
  logic       done_ok;
  logic       timeout_hit;

  rr_arb2 u_rr (
    .valid   (req_valid),
    .last    (last_grant),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  // The go cycle is excluded so a stale done from the previous op cannot complete this one.
  assign done_ok = (state == ST_WAIT) && alu_done && !alu_go;
  assign busy    = (state != ST_IDLE);

`ifdef ALU_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] timer;

  assign timeout_hit = (state == ST_WAIT) && !done_ok && (timer == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      timer     <= '0;
      rsp_error <= 1'b0;
    end else begin
      if (state == ST_ISSUE) begin
        timer <= '0;
      end else if (state == ST_WAIT) begin
        timer <= timer + CNT_W'(1);
      end
      if (done_ok) begin
        rsp_error <= 1'b0;
      end else if (timeout_hit) begin
        rsp_error <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_error   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (gnt_any) state_next = ST_ISSUE;
      ST_ISSUE: if (alu_ready) state_next = ST_WAIT;
      ST_WAIT:  if (done_ok || timeout_hit) state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      alu_go     <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      alu_go    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            req_ready  <= gnt_id ? 2'b10 : 2'b01;
            last_grant <= gnt_id;
            alu_opcode <= gnt_id ? req_opcode[5:3] : req_opcode[2:0];
            alu_a      <= gnt_id ? req_a[7:4] : req_a[3:0];
            alu_b      <= gnt_id ? req_b[7:4] : req_b[3:0];
          end
        end
        ST_ISSUE: begin
          if (alu_ready) alu_go <= 1'b1;
        end
        ST_WAIT: begin
          // last_grant still names the owner of the in-flight op.
          if (done_ok) begin
            rsp_valid  <= last_grant ? 2'b10 : 2'b01;
            rsp_result <= alu_result;
            rsp_cout   <= alu_cout;
          end else if (timeout_hit) begin
            rsp_valid  <= last_grant ? 2'b10 : 2'b01;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
